// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the burst memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } mem_ctrl_state_t;

  localparam int unsigned MEMCTRL_BURSTLEN = 4;
  localparam int unsigned MEMCTRL_STATS_W  = 16;

  // Width of the in-block beat offset; zero for single-beat bursts.
  function automatic int unsigned burst_off_w(input int unsigned burstlen);
    return (burstlen > 1) ? $clog2(burstlen) : 0;
  endfunction

endpackage

// File: rtl/mem_burst_addr.sv
// Beat counter and critical-word-first address generator; the offset wraps
// inside the aligned burst block and never carries into the upper bits.
module mem_burst_addr
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned BURSTLEN  = MEMCTRL_BURSTLEN
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 load_i,
  input  logic [ADDRWIDTH-1:0] base_i,
  input  logic                 inc_i,
  output logic [ADDRWIDTH-1:0] addr_o,
  output logic                 last_o
);

  localparam int unsigned OFFW = burst_off_w(BURSTLEN);

  logic [ADDRWIDTH-1:0] base_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      base_q <= '0;
    end else if (load_i) begin
      base_q <= base_i;
    end
  end

  generate
    if (OFFW == 0) begin : g_single
      assign addr_o = base_q;
      assign last_o = 1'b1;
    end else begin : g_multi
      logic [OFFW-1:0] beat_q;
      logic [OFFW-1:0] beat_d;
      logic [OFFW-1:0] off;

      always_comb begin
        beat_d = beat_q;
        if (load_i) begin
          beat_d = '0;
        end else if (inc_i) begin
          beat_d = beat_q + OFFW'(1);
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          beat_q <= '0;
        end else begin
          beat_q <= beat_d;
        end
      end

      assign off    = base_q[OFFW-1:0] + beat_q;
      assign addr_o = {base_q[ADDRWIDTH-1:OFFW], off};
      assign last_o = (beat_q == OFFW'(BURSTLEN - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_ctrl.sv
// Burst controller in front of a synchronous tristate-bus memory.
// Optional beat statistics outputs are enabled with MEMCTRL_STATS_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEMDEPTH  = 256,
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned ADDRWIDTH = $clog2(MEMDEPTH),
  parameter int unsigned BURSTLEN  = MEMCTRL_BURSTLEN
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [ADDRWIDTH-1:0] reqAddr,
  input  logic                 wrValid,
  output logic                 wrReady,
  input  logic [DATAWIDTH-1:0] wrData,
  output logic                 rspValid,
  output logic [DATAWIDTH-1:0] rspData,
  output logic                 busy,
  output logic                 rdEn,
  output logic                 wrEn,
  output logic [ADDRWIDTH-1:0] Addr,
  inout  tri   [DATAWIDTH-1:0] Data
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [MEMCTRL_STATS_W-1:0] rdBeats,
  output logic [MEMCTRL_STATS_W-1:0] wrBeats
`endif
);

  mem_ctrl_state_t      state_q;
  mem_ctrl_state_t      state_d;
  logic                 load;
  logic                 inc;
  logic                 last;
  logic [ADDRWIDTH-1:0] beat_addr;
  logic                 rsp_valid_q;
  logic [DATAWIDTH-1:0] rsp_data_q;

  mem_burst_addr #(
    .ADDRWIDTH(ADDRWIDTH),
    .BURSTLEN (BURSTLEN)
  ) u_burst_addr (
    .clk   (clk),
    .resetN(resetN),
    .load_i(load),
    .base_i(reqAddr),
    .inc_i (inc),
    .addr_o(beat_addr),
    .last_o(last)
  );

  // Next-state and counter control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reqValid) begin
          load    = 1'b1;
          state_d = reqWrite ? WRITE : READ;
        end
      end
      READ: begin
        inc = 1'b1;
        if (last) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (wrValid) begin
          inc = 1'b1;
          if (last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read data is captured off the bus at the end of each rdEn cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rdEn;
      if (rdEn) begin
        rsp_data_q <= Data;
      end
    end
  end

  assign reqReady = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rdEn     = (state_q == READ);
  assign wrReady  = (state_q == WRITE);
  assign wrEn     = wrReady & wrValid;
  assign Addr     = beat_addr;
  assign rspValid = rsp_valid_q;
  assign rspData  = rsp_data_q;

  // The bus is only driven while a write beat is in flight.
  assign Data = wrEn ? wrData : {DATAWIDTH{1'bz}};

`ifdef MEMCTRL_STATS_EN
  logic [MEMCTRL_STATS_W-1:0] rd_beats_q;
  logic [MEMCTRL_STATS_W-1:0] wr_beats_q;

  // Saturating beat counters.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_beats_q <= '0;
      wr_beats_q <= '0;
    end else begin
      if (rdEn && (rd_beats_q != {MEMCTRL_STATS_W{1'b1}})) begin
        rd_beats_q <= rd_beats_q + MEMCTRL_STATS_W'(1);
      end
      if (wrEn && (wr_beats_q != {MEMCTRL_STATS_W{1'b1}})) begin
        wr_beats_q <= wr_beats_q + MEMCTRL_STATS_W'(1);
      end
    end
  end

  assign rdBeats = rd_beats_q;
  assign wrBeats = wr_beats_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl with a behavioural tristate memory.
module tb_mem_ctrl;

  localparam logic [15:0] KEEP = 16'h5A5A;
  localparam logic [15:0] IDW  = 16'hA5A5;

  logic        clk;
  logic        resetN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [7:0]  reqAddr;
  logic        wrValid;
  logic        wrReady;
  logic [15:0] wrData;
  logic        rspValid;
  logic [15:0] rspData;
  logic        busy;
  logic        rdEn;
  logic        wrEn;
  logic [7:0]  Addr;
  tri   [15:0] Data;
`ifdef MEMCTRL_STATS_EN
  logic [15:0] rdBeats;
  logic [15:0] wrBeats;
  int          rd_cnt;
  int          wr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:255];

  mem_ctrl dut (
    .clk     (clk),
    .resetN  (resetN),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqWrite(reqWrite),
    .reqAddr (reqAddr),
    .wrValid (wrValid),
    .wrReady (wrReady),
    .wrData  (wrData),
    .rspValid(rspValid),
    .rspData (rspData),
    .busy    (busy),
    .rdEn    (rdEn),
    .wrEn    (wrEn),
    .Addr    (Addr),
    .Data    (Data)
`ifdef MEMCTRL_STATS_EN
    ,
    .rdBeats (rdBeats),
    .wrBeats (wrBeats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; a keeper pattern marks a released bus.
  always @(posedge clk) if (wrEn) mem[Addr] <= Data;
  assign Data = rdEn ? mem[Addr] : (wrEn ? 16'hzzzz : KEEP);

`ifdef MEMCTRL_STATS_EN
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      if (rdEn) rd_cnt <= rd_cnt + 1;
      if (wrEn) wr_cnt <= wr_cnt + 1;
    end
  end
`endif

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Bus rules that hold in every cycle.
  always @(negedge clk) begin
    chk("excl_rd_wr", 16'(rdEn & wrEn), 16'h0);
    if (!rdEn && !wrEn) chk("bus_released", Data, KEEP);
  end

  typedef struct {
    logic        rv;
    logic        rw;
    logic [7:0]  ra;
    logic        wv;
    logic [15:0] wd;
    logic        rr;
    logic        wr;
    logic        bz;
    logic        rd;
    logic        we;
    logic [7:0]  ad;
    logic        sv;
    logic [15:0] sd;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic rw, input logic [7:0] ra,
                              input logic wv, input logic [15:0] wd,
                              input logic rr, input logic wr, input logic bz,
                              input logic rd, input logic we, input logic [7:0] ad,
                              input logic sv, input logic [15:0] sd);
    vec_t v;
    v.rv = rv; v.rw = rw; v.ra = ra; v.wv = wv; v.wd = wd;
    v.rr = rr; v.wr = wr; v.bz = bz; v.rd = rd; v.we = we;
    v.ad = ad; v.sv = sv; v.sd = sd;
    return v;
  endfunction

  vec_t tbl [29];

  task automatic drive(input logic rv, input logic rw, input logic [7:0] ra,
                       input logic wv, input logic [15:0] wd);
    @(posedge clk);
    #1;
    reqValid = rv; reqWrite = rw; reqAddr = ra; wrValid = wv; wrData = wd;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " reqReady"}, 16'(reqReady), 16'h1);
    chk({tag, " wrReady"},  16'(wrReady),  16'h0);
    chk({tag, " rspValid"}, 16'(rspValid), 16'h0);
    chk({tag, " rspData"},  rspData,       16'h0);
    chk({tag, " busy"},     16'(busy),     16'h0);
    chk({tag, " rdEn"},     16'(rdEn),     16'h0);
    chk({tag, " wrEn"},     16'(wrEn),     16'h0);
    chk({tag, " Addr"},     16'(Addr),     16'h0);
    chk({tag, " Data"},     Data,          KEEP);
  endtask

  logic [15:0] exp_rd [4];

  initial begin
    // Write 0x10 block, wrapped read from 0x12, gapped write to 0x20,
    // then reqValid held high across a read burst.
    tbl[0]  = mk(1,1,8'h10,0,IDW,     1,0,0,0,0,8'h00,0,16'h0000);
    tbl[1]  = mk(0,0,8'h00,1,16'hA000,0,1,1,0,1,8'h10,0,16'h0000);
    tbl[2]  = mk(0,0,8'h00,1,16'hA001,0,1,1,0,1,8'h11,0,16'h0000);
    tbl[3]  = mk(0,0,8'h00,1,16'hA002,0,1,1,0,1,8'h12,0,16'h0000);
    tbl[4]  = mk(0,0,8'h00,1,16'hA003,0,1,1,0,1,8'h13,0,16'h0000);
    tbl[5]  = mk(1,0,8'h12,0,IDW,     1,0,0,0,0,8'h00,0,16'h0000);
    tbl[6]  = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h12,0,16'h0000);
    tbl[7]  = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h13,1,16'hA002);
    tbl[8]  = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h10,1,16'hA003);
    tbl[9]  = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h11,1,16'hA000);
    tbl[10] = mk(1,1,8'h20,0,IDW,     1,0,0,0,0,8'h00,1,16'hA001);
    tbl[11] = mk(0,0,8'h00,1,16'hB000,0,1,1,0,1,8'h20,0,16'h0000);
    tbl[12] = mk(0,0,8'h00,0,IDW,     0,1,1,0,0,8'h00,0,16'h0000);
    tbl[13] = mk(0,0,8'h00,0,IDW,     0,1,1,0,0,8'h00,0,16'h0000);
    tbl[14] = mk(0,0,8'h00,1,16'hB001,0,1,1,0,1,8'h21,0,16'h0000);
    tbl[15] = mk(0,0,8'h00,1,16'hB002,0,1,1,0,1,8'h22,0,16'h0000);
    tbl[16] = mk(0,0,8'h00,1,16'hB003,0,1,1,0,1,8'h23,0,16'h0000);
    tbl[17] = mk(1,0,8'h20,0,IDW,     1,0,0,0,0,8'h00,0,16'h0000);
    tbl[18] = mk(1,0,8'h22,0,IDW,     0,0,1,1,0,8'h20,0,16'h0000);
    tbl[19] = mk(1,0,8'h22,0,IDW,     0,0,1,1,0,8'h21,1,16'hB000);
    tbl[20] = mk(1,0,8'h22,0,IDW,     0,0,1,1,0,8'h22,1,16'hB001);
    tbl[21] = mk(1,0,8'h22,0,IDW,     0,0,1,1,0,8'h23,1,16'hB002);
    tbl[22] = mk(1,0,8'h22,0,IDW,     1,0,0,0,0,8'h00,1,16'hB003);
    tbl[23] = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h22,0,16'h0000);
    tbl[24] = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h23,1,16'hB002);
    tbl[25] = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h20,1,16'hB003);
    tbl[26] = mk(0,0,8'h00,0,IDW,     0,0,1,1,0,8'h21,1,16'hB000);
    tbl[27] = mk(0,0,8'h00,0,IDW,     1,0,0,0,0,8'h00,1,16'hB001);
    tbl[28] = mk(0,0,8'h00,0,IDW,     1,0,0,0,0,8'h00,0,16'h0000);

    resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    wrValid = 1'b0; wrData = IDW;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    resetN = 1'b1;

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rv, tbl[i].rw, tbl[i].ra, tbl[i].wv, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d reqReady", i), 16'(reqReady), 16'(tbl[i].rr));
      chk($sformatf("v%0d wrReady", i),  16'(wrReady),  16'(tbl[i].wr));
      chk($sformatf("v%0d busy", i),     16'(busy),     16'(tbl[i].bz));
      chk($sformatf("v%0d rdEn", i),     16'(rdEn),     16'(tbl[i].rd));
      chk($sformatf("v%0d wrEn", i),     16'(wrEn),     16'(tbl[i].we));
      chk($sformatf("v%0d rspValid", i), 16'(rspValid), 16'(tbl[i].sv));
      if (tbl[i].rd || tbl[i].we) chk($sformatf("v%0d Addr", i), 16'(Addr), 16'(tbl[i].ad));
      if (tbl[i].we) chk($sformatf("v%0d Data", i), Data, tbl[i].wd);
      if (tbl[i].sv) chk($sformatf("v%0d rspData", i), rspData, tbl[i].sd);
    end

    // Fill the 0x30 block, then abandon a rewrite of it after two beats.
    drive(1, 1, 8'h30, 0, IDW);
    for (int b = 0; b < 4; b++) drive(0, 0, 8'h00, 1, 16'hD000 + 16'(b));
    drive(1, 1, 8'h30, 0, IDW);
    drive(0, 0, 8'h00, 1, 16'hC000);
    drive(0, 0, 8'h00, 1, 16'hC001);
    drive(0, 0, 8'h00, 1, 16'hC002);
    @(negedge clk);
    chk("rst_pre wrEn", 16'(wrEn), 16'h1);
    chk("rst_pre Addr", 16'(Addr), 16'h0032);
    #2;
    resetN = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold wrEn", 16'(wrEn), 16'h0);
    resetN = 1'b1;
    wrValid = 1'b0;
    wrData = IDW;

    exp_rd[0] = 16'hC000; exp_rd[1] = 16'hC001;
    exp_rd[2] = 16'hD002; exp_rd[3] = 16'hD003;
    drive(1, 0, 8'h30, 0, IDW);
    for (int c = 1; c <= 6; c++) begin
      drive(0, 0, 8'h00, 0, IDW);
      @(negedge clk);
      chk($sformatf("rd30 c%0d rspValid", c), 16'(rspValid), 16'((c >= 2) && (c <= 5)));
      if (c >= 2 && c <= 5) chk($sformatf("rd30 c%0d rspData", c), rspData, exp_rd[c-2]);
    end

`ifdef MEMCTRL_STATS_EN
    chk("stats rdBeats", rdBeats, 16'(rd_cnt));
    chk("stats wrBeats", wrBeats, 16'(wr_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
